// File: rtl/hpi_pkg.sv
// ============================================================================
// hpi_pkg : shared types, default phase timing and counter sizing for the
//           HPI I/O sequencer.                               Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package hpi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } hpi_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } hpi_op_t;

    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_STROBE_CYC = 3;
    localparam int DEF_HOLD_CYC   = 1;

    // The counter holds N-1 of the longest phase; never narrower than one bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hpi_phase_counter.sv
// ============================================================================
// hpi_phase_counter : loadable down-counter that flags the final phase cycle.
//                                                            Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hpi_phase_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

`default_nettype wire

// File: rtl/hpi_io_sequencer.sv
// ============================================================================
// hpi_io_sequencer : turns slow PIO strobe edges into fixed-timing CY7C67200
//                    HPI bus cycles. Optional macro: HPI_IRQ_SYNC_EN.
//                                                            Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hpi_io_sequencer
    import hpi_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        hpi_cs_n_in,
    input  logic [1:0]  hpi_addr_in,
    input  logic [15:0] hpi_wdata,
    input  logic        hpi_rd_n_in,
    input  logic        hpi_wr_n_in,
    output logic [15:0] hpi_rdata,
    output logic        hpi_busy,
    output logic        hpi_err,
    output logic [1:0]  OTG_ADDR,
    output logic        OTG_CS_N,
    output logic        OTG_RD_N,
    output logic        OTG_WR_N,
    inout  wire  [15:0] OTG_DATA,
    input  logic        OTG_INT,
    output logic        otg_int_export
);

    localparam int CW = cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC);

    hpi_state_t    state;
    hpi_op_t       op;
    logic          rd_prev;
    logic          wr_prev;
    logic [15:0]   wdata_q;
    logic          data_oe;

    logic          rd_fall;
    logic          wr_fall;
    logic          cs_fall;
    logic          trigger;
    logic          cnt_load;
    logic [CW-1:0] cnt_load_val;
    logic          cnt_done;

    assign rd_fall = rd_prev & ~hpi_rd_n_in;
    assign wr_fall = wr_prev & ~hpi_wr_n_in;
    assign cs_fall = ~hpi_cs_n_in & (rd_fall | wr_fall);
    assign trigger = (state == IDLE) & ~hpi_cs_n_in & (rd_fall ^ wr_fall);

    assign OTG_DATA = data_oe ? wdata_q : 16'hzzzz;

    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state)
            IDLE: begin
                cnt_load     = trigger;
                cnt_load_val = CW'(SETUP_CYC - 1);
            end
            SETUP: begin
                cnt_load     = cnt_done;
                cnt_load_val = CW'(STROBE_CYC - 1);
            end
            STROBE: begin
                cnt_load     = cnt_done;
                cnt_load_val = CW'(HOLD_CYC - 1);
            end
            default: begin
                cnt_load     = 1'b0;
                cnt_load_val = '0;
            end
        endcase
    end

    hpi_phase_counter #(
        .WIDTH    (CW)
    ) u_phase_counter (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .done     (cnt_done)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state     <= IDLE;
            op        <= OP_RD;
            rd_prev   <= 1'b1;
            wr_prev   <= 1'b1;
            wdata_q   <= '0;
            data_oe   <= 1'b0;
            hpi_rdata <= '0;
            hpi_busy  <= 1'b0;
            hpi_err   <= 1'b0;
            OTG_ADDR  <= '0;
            OTG_CS_N  <= 1'b1;
            OTG_RD_N  <= 1'b1;
            OTG_WR_N  <= 1'b1;
        end else begin
            rd_prev <= hpi_rd_n_in;
            wr_prev <= hpi_wr_n_in;

            // Simultaneous strobes, or a new request during a cycle, are rejected.
            if (cs_fall && ((state != IDLE) || (rd_fall && wr_fall))) begin
                hpi_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (trigger) begin
                        state    <= SETUP;
                        op       <= wr_fall ? OP_WR : OP_RD;
                        OTG_ADDR <= hpi_addr_in;
                        wdata_q  <= hpi_wdata;
                        data_oe  <= wr_fall;
                        OTG_CS_N <= 1'b0;
                        hpi_busy <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_done) begin
                        state <= STROBE;
                        if (op == OP_WR) OTG_WR_N <= 1'b0;
                        else             OTG_RD_N <= 1'b0;
                    end
                end
                STROBE: begin
                    if (cnt_done) begin
                        state    <= HOLD;
                        OTG_RD_N <= 1'b1;
                        OTG_WR_N <= 1'b1;
                        if (op == OP_RD) hpi_rdata <= OTG_DATA;
                    end
                end
                HOLD: begin
                    if (cnt_done) begin
                        state    <= IDLE;
                        OTG_CS_N <= 1'b1;
                        data_oe  <= 1'b0;
                        hpi_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HPI_IRQ_SYNC_EN
    logic [1:0] irq_sync;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irq_sync <= 2'b00;
        end else begin
            irq_sync <= {irq_sync[0], OTG_INT};
        end
    end

    assign otg_int_export = irq_sync[1];
`else
    logic unused_otg_int;
    assign unused_otg_int = OTG_INT;
    assign otg_int_export = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hpi_io_sequencer.sv
// ============================================================================
// tb_hpi_io_sequencer : scoreboard bench for hpi_io_sequencer.
//                                                            Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hpi_io_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_n = 1'b1;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic        otg_int = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [15:0] wdata = 16'h0;
    logic [15:0] model_rdata = 16'h0;

    wire  [15:0] otg_data;
    logic [15:0] rdata;
    logic        busy;
    logic        err;
    logic [1:0]  otg_addr;
    logic        otg_cs_n;
    logic        otg_rd_n;
    logic        otg_wr_n;
    logic        irq;

    // Peripheral model: drives read data only while the read strobe is low.
    assign otg_data = otg_rd_n ? 16'hzzzz : model_rdata;

    always #5 clk = ~clk;

    hpi_io_sequencer dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .hpi_cs_n_in    (cs_n),
        .hpi_addr_in    (addr),
        .hpi_wdata      (wdata),
        .hpi_rd_n_in    (rd_n),
        .hpi_wr_n_in    (wr_n),
        .hpi_rdata      (rdata),
        .hpi_busy       (busy),
        .hpi_err        (err),
        .OTG_ADDR       (otg_addr),
        .OTG_CS_N       (otg_cs_n),
        .OTG_RD_N       (otg_rd_n),
        .OTG_WR_N       (otg_wr_n),
        .OTG_DATA       (otg_data),
        .OTG_INT        (otg_int),
        .otg_int_export (irq)
    );

    typedef struct {
        logic        is_wr;
        logic [1:0]  addr;
        logic [15:0] data;
        logic [15:0] rdata_after;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        in_txn = 1'b0;
    int          cyc, wr_cnt, rd_cnt, strobe_first, oe_cnt;
    logic [1:0]  obs_addr;
    logic [15:0] obs_data;
    logic        addr_bad, data_bad, busy_bad;
    txn_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_txn = 1'b0;
        end else if (!otg_cs_n) begin
            if (!in_txn) begin
                in_txn = 1'b1;
                cyc = 0; wr_cnt = 0; rd_cnt = 0; strobe_first = 0; oe_cnt = 0;
                addr_bad = 1'b0; data_bad = 1'b0; busy_bad = 1'b0;
                obs_addr = otg_addr;
                obs_data = otg_data;
            end
            cyc++;
            if (!otg_wr_n) begin wr_cnt++; if (strobe_first == 0) strobe_first = cyc; end
            if (!otg_rd_n) begin rd_cnt++; if (strobe_first == 0) strobe_first = cyc; end
            if (otg_addr !== obs_addr) addr_bad = 1'b1;
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (dut.data_oe) begin
                oe_cnt++;
                if (otg_data !== obs_data) data_bad = 1'b1;
            end
        end else if (in_txn) begin
            in_txn = 1'b0;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_txn: got bus cycle addr=%0d required none", obs_addr);
            end else begin
                e = exp_q.pop_front();
                check("txn_cs_len",       cyc,          5);
                check("txn_wr_strobe",    wr_cnt,       e.is_wr ? 3 : 0);
                check("txn_rd_strobe",    rd_cnt,       e.is_wr ? 0 : 3);
                check("txn_strobe_start", strobe_first, 2);
                check("txn_addr",         obs_addr,     e.addr);
                check("txn_addr_stable",  addr_bad,     0);
                check("txn_busy_during",  busy_bad,     0);
                check("txn_busy_after",   busy,         0);
                check("txn_drive_cycles", oe_cnt,       e.is_wr ? 5 : 0);
                if (e.is_wr) begin
                    check("txn_wdata",        obs_data, e.data);
                    check("txn_wdata_stable", data_bad, 0);
                end
                check("txn_rdata", rdata, e.rdata_after);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_done"}, busy, 0);
    endtask

    task automatic wait_rd_strobe(input string name);
        int n = 0;
        while (otg_rd_n && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_strobe_seen"}, otg_rd_n, 0);
    endtask

    task automatic bus_op(input logic is_wr, input logic [1:0] a, input logic [15:0] d,
                          input logic [15:0] rd_after);
        txn_t t;
        t.is_wr = is_wr; t.addr = a; t.data = d; t.rdata_after = rd_after;
        exp_q.push_back(t);
        @(posedge clk); #1;
        cs_n = 1'b0; addr = a; wdata = d;
        if (!is_wr) model_rdata = d;
        @(posedge clk); #1;
        if (is_wr) wr_n = 1'b0;
        else       rd_n = 1'b0;
        @(posedge clk); #1;
        addr = ~a; wdata = ~d;
        wait_idle(is_wr ? "write" : "read");
        rd_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic exp_irq;

        repeat (3) @(posedge clk);
        #1;
        check("reset_cs_n",  otg_cs_n, 1);
        check("reset_rd_n",  otg_rd_n, 1);
        check("reset_wr_n",  otg_wr_n, 1);
        check("reset_addr",  otg_addr, 0);
        check("reset_oe",    dut.data_oe, 0);
        check("reset_rdata", rdata, 0);
        check("reset_busy",  busy, 0);
        check("reset_err",   err, 0);
        check("reset_irq",   irq, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        bus_op(1'b1, 2'd2, 16'h1234, 16'h0000);
        bus_op(1'b0, 2'd1, 16'hBEEF, 16'hBEEF);
        bus_op(1'b1, 2'd3, 16'h0000, 16'hBEEF);
        #1;
        check("rdata_kept_after_write", rdata, 16'hBEEF);

        // Strobe falls with chip select high: nothing happens.
        @(posedge clk); #1;
        cs_n = 1'b1; wr_n = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("cs_high_err", err, 0);
        check("cs_high_busy", busy, 0);
        wr_n = 1'b1;
        repeat (2) @(posedge clk);

        // Write strobe falls while a read is in its strobe phase.
        exp_q.push_back('{is_wr: 1'b0, addr: 2'd1, data: 16'hA5C3, rdata_after: 16'hA5C3});
        @(posedge clk); #1;
        cs_n = 1'b0; addr = 2'd1; model_rdata = 16'hA5C3;
        @(posedge clk); #1;
        rd_n = 1'b0;
        wait_rd_strobe("midflight");
        wr_n = 1'b0;
        wait_idle("midflight");
        check("midflight_err", err, 1);
        rd_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midflight_single_txn", exp_q.size(), 0);

        // Reset asserted during the read strobe phase.
        @(posedge clk); #1;
        cs_n = 1'b0; addr = 2'd2; model_rdata = 16'h7777;
        @(posedge clk); #1;
        rd_n = 1'b0;
        wait_rd_strobe("abort");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_rd_n",  otg_rd_n, 1);
        check("abort_cs_n",  otg_cs_n, 1);
        check("abort_oe",    dut.data_oe, 0);
        check("abort_rdata", rdata, 0);
        check("abort_busy",  busy, 0);
        check("abort_err",   err, 0);
        rd_n = 1'b1; cs_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        bus_op(1'b0, 2'd0, 16'h0F0F, 16'h0F0F);

        // Both strobes fall together with chip select low.
        @(posedge clk); #1;
        cs_n = 1'b0;
        @(posedge clk); #1;
        rd_n = 1'b0; wr_n = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("both_fall_err", err, 1);
        check("both_fall_busy", busy, 0);
        rd_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1;
        repeat (2) @(posedge clk);

        // Interrupt pulse of three cycles.
        @(posedge clk); #1;
        otg_int = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (k == 3) otg_int = 1'b0;
            @(negedge clk);
`ifdef HPI_IRQ_SYNC_EN
            exp_irq = (k >= 2 && k <= 4);
`else
            exp_irq = 1'b0;
`endif
            check($sformatf("irq_k%0d", k), irq, exp_irq);
        end

        repeat (4) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
